// File: rtl/surf_dout_pkg.sv
// rtl/surf_dout_pkg.sv - shared event framing constants and FSM state for the dout byte path
// Also used by the TURFIO splicer so both ends agree on event length and header layout.
package surf_dout_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HEADER  = 2'd1,
      DATA    = 2'd2,
      HOLDOFF = 2'd3
   } dout_state_e;

   localparam int NUM_CH       = 8;
   localparam int BYTES_PER_CH = 1536;
   localparam int HDR_BYTES    = 4;
   localparam int NUM_BYTES    = NUM_CH * BYTES_PER_CH + HDR_BYTES;
   localparam int BCNT_W       = $clog2(NUM_BYTES);
   localparam int HOLD_W       = 25;

   // Byte 0 carries the framing bit in place of header bit 15, which is otherwise ignored.
   function automatic logic [7:0] hdr_byte(input logic [31:0] hdr, input logic [1:0] idx);
      logic [7:0] b;
      unique case (idx)
         2'd0:    b = hdr[15:8] | 8'h80;
         2'd1:    b = hdr[7:0];
         2'd2:    b = hdr[31:24];
         default: b = hdr[23:16];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/surf_dout_event_tx.sv
// rtl/surf_dout_event_tx.sv - serialises one header plus channel samples per event onto the dout byte stream
// The receiver cannot backpressure, so a starved data stream is padded with zeros to keep framing.
module surf_dout_event_tx
   import surf_dout_pkg::*;
#(
   parameter int NUM_CH       = 8,
   parameter int BYTES_PER_CH = 1536
) (
   input  logic        aclk,
   input  logic        rst,
   input  logic        dout_ce_i,
   input  logic [31:0] s_hdr_tdata,
   input  logic        s_hdr_tvalid,
   output logic        s_hdr_tready,
   input  logic [7:0]  s_data_tdata,
   input  logic        s_data_tvalid,
   output logic        s_data_tready,
   input  logic [23:0] rdholdoff_i,
   output logic [7:0]  m_dout_tdata,
   output logic        m_dout_tvalid,
   output logic        m_dout_tlast,
   output logic        err_o,
   output logic        busy_o
);

   localparam int            EV_BYTES = NUM_CH * BYTES_PER_CH + HDR_BYTES;
   localparam int            CW       = $clog2(EV_BYTES);
   localparam logic [CW-1:0] LAST_CNT = CW'(EV_BYTES - 1);

   dout_state_e       state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [31:0]       hdr_q, hdr_d;
   logic [7:0]        tdata_q, tdata_d;
   logic              tvalid_q, tvalid_d;
   logic              tlast_q, tlast_d;
   logic              err_q, err_d;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      hold_d        = hold_q;
      hdr_d         = hdr_q;
      tdata_d       = tdata_q;
      tvalid_d      = 1'b0;
      tlast_d       = 1'b0;
      err_d         = err_q;
      s_hdr_tready  = 1'b0;
      s_data_tready = 1'b0;

      case (state_q)
         IDLE: begin
            s_hdr_tready = 1'b1;
            cnt_d        = '0;
            if (s_hdr_tvalid) begin
               hdr_d   = s_hdr_tdata;
               state_d = HEADER;
            end
         end
         HEADER: begin
            if (dout_ce_i) begin
               tvalid_d = 1'b1;
               tdata_d  = hdr_byte(hdr_q, cnt_q[1:0]);
               cnt_d    = cnt_q + CW'(1);
               if (cnt_q[1:0] == 2'd3) begin
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            s_data_tready = dout_ce_i;
            if (dout_ce_i) begin
               tvalid_d = 1'b1;
               cnt_d    = cnt_q + CW'(1);
               if (s_data_tvalid) begin
                  tdata_d = s_data_tdata;
               end else begin
                  tdata_d = 8'h00;
                  err_d   = 1'b1;
               end
               if (cnt_q == LAST_CNT) begin
                  tlast_d = 1'b1;
                  hold_d  = {1'b0, rdholdoff_i};
                  state_d = HOLDOFF;
               end
            end
         end
         HOLDOFF: begin
            // Counter runs one tick past zero so a holdoff of 0 still spends one ce tick here.
            if (hold_q[HOLD_W-1]) begin
               state_d = IDLE;
            end else if (dout_ce_i) begin
               hold_d = hold_q - HOLD_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      if (rst) begin
         s_hdr_tready  = 1'b0;
         s_data_tready = 1'b0;
      end
   end

   always_ff @(posedge aclk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         hold_q   <= '0;
         hdr_q    <= '0;
         tdata_q  <= 8'h00;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hold_q   <= hold_d;
         hdr_q    <= hdr_d;
         tdata_q  <= tdata_d;
         tvalid_q <= tvalid_d;
         tlast_q  <= tlast_d;
         err_q    <= err_d;
      end
   end

   assign m_dout_tdata  = tdata_q;
   assign m_dout_tvalid = tvalid_q;
   assign m_dout_tlast  = tlast_q;
   assign err_o         = err_q;
   assign busy_o        = (state_q != IDLE) && !rst;

endmodule
